// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings, frame FSM states and
// small helpers used by both the transmitter and the matching receiver.
package uart_pkg;

  // Line parity selection as driven on the parity_mode input.
  typedef enum logic [1:0] {
    PARITY_NONE     = 2'b00,
    PARITY_EVEN     = 2'b01,
    PARITY_ODD      = 2'b10,
    PARITY_NONE_ALT = 2'b11
  } parity_mode_e;

  // Frame sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // True when the mode inserts a parity bit (the reserved code 11 means none).
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

  // Parity bit from the XOR of all data bits: even passes it, odd inverts it.
  function automatic logic parity_from_xor(input logic [1:0] mode, input logic data_xor);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port. Writes to a full
// FIFO and reads from an empty one are ignored.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == C_FULL);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = wr_en && !full;
  assign w_pop  = rd_en && !empty;

  // Storage write.
  // NOTE: the data array has no reset; occupancy is tracked by the pointers
  // and count, so clearing the RAM would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sync_fifo

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: a small transmit FIFO feeding a frame FSM
// that serialises start, data (LSB first), optional parity and 1/2 stop bits.
// Back-to-back frames are emitted with no idle gap when the FIFO has data.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int              DIV        = CLOCK_FREQ / BAUD_RATE;
  localparam int              CW         = $clog2(DIV);
  localparam int              BW         = $clog2(DATA_BITS);
  localparam logic [CW-1:0]   C_DIV_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0]   C_BIT_LAST = BW'(DATA_BITS - 1);

  uart_state_e          r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_en;
  logic                 r_par_bit;
  logic                 r_two_stop;
  logic                 r_stop_idx;
  logic                 r_serial;
  logic                 r_busy;
  logic                 r_rst_done;

  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_fifo_dout;
  logic                 w_push;
  logic                 w_bit_end;
  logic                 w_last_stop;
  logic                 w_load;

  // Ready depends only on registered state, never on data_in_valid, and stays
  // low until the first edge after reset release.
  assign data_in_ready = r_rst_done && !w_full;
  assign w_push        = data_in_valid && data_in_ready;

  assign w_bit_end   = (r_cnt == C_DIV_LAST);
  assign w_last_stop = !r_two_stop || r_stop_idx;
  // Pop the head either from IDLE or at the end of the final stop period.
  assign w_load      = !w_empty &&
                       ((r_state == ST_IDLE) ||
                        ((r_state == ST_STOP) && w_bit_end && w_last_stop));

  assign serial_out = r_serial;
  assign tx_busy    = r_busy;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (w_push),
    .din   (data_in),
    .full  (w_full),
    .rd_en (w_load),
    .dout  (w_fifo_dout),
    .empty (w_empty),
    .count (fifo_count)
  );

  // Marks that the block has seen a clock edge since reset was released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_done <= 1'b0;
    else      r_rst_done <= 1'b1;
  end

  // Frame FSM with registered line and busy outputs. A load latches the
  // character and its framing options so later input changes do not affect
  // the frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= 1'b0;
      r_stop_idx <= 1'b0;
      r_serial   <= 1'b1;
      r_busy     <= 1'b0;
    end else if (w_load) begin
      r_shift    <= w_fifo_dout;
      r_par_en   <= parity_enabled(parity_mode);
      r_par_bit  <= parity_from_xor(parity_mode, ^w_fifo_dout);
      r_two_stop <= two_stop;
      r_stop_idx <= 1'b0;
      r_bit      <= '0;
      r_cnt      <= '0;
      r_state    <= ST_START;
      r_serial   <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt    <= '0;
          r_serial <= 1'b1;
          r_busy   <= 1'b0;
        end

        ST_START: begin
          if (w_bit_end) begin
            r_cnt    <= '0;
            r_bit    <= '0;
            r_state  <= ST_DATA;
            r_serial <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == C_BIT_LAST) begin
              if (r_par_en) begin
                r_state  <= ST_PARITY;
                r_serial <= r_par_bit;
              end else begin
                r_state    <= ST_STOP;
                r_stop_idx <= 1'b0;
                r_serial   <= 1'b1;
              end
            end else begin
              r_bit    <= r_bit + 1'b1;
              r_shift  <= r_shift >> 1;
              r_serial <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_PARITY: begin
          if (w_bit_end) begin
            r_cnt      <= '0;
            r_state    <= ST_STOP;
            r_stop_idx <= 1'b0;
            r_serial   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (!w_last_stop) begin
              r_stop_idx <= 1'b1;
            end else begin
              // Non-empty FIFO was handled by the load branch above.
              r_state  <= ST_IDLE;
              r_busy   <= 1'b0;
              r_serial <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_cnt    <= '0;
          r_state  <= ST_IDLE;
          r_serial <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule : uart_tx_param

// File: tb/tb_uart_tx_param.sv
// Testbench for uart_tx_param with DIV = 10, 8 data bits, 4-entry FIFO.
module tb_uart_tx_param;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       serial_out;
  logic       tx_busy;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       two;
    logic       has_par;
    logic       par;
    int         cycles;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] bb[6];

  uart_tx_param #(
    .CLOCK_FREQ (1000),
    .BAUD_RATE  (100),
    .DATA_BITS  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .parity_mode   (parity_mode),
    .two_stop      (two_stop),
    .serial_out    (serial_out),
    .tx_busy       (tx_busy),
    .fifo_count    (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at the negedge of frame cycle 0; returns at the negedge of the
  // frame's last cycle.
  task automatic expect_frame(input logic [7:0] d, input logic has_par, input logic par,
                              input int cycles);
    for (int i = 0; i < cycles; i++) begin
      int   b;
      logic e;
      b = i / 10;
      if (b == 0)                  e = 1'b0;
      else if (b <= 8)             e = d[b-1];
      else if (b == 9 && has_par)  e = par;
      else                         e = 1'b1;
      check($sformatf("line d%0h c%0d", d, i), serial_out, e);
      check($sformatf("busy d%0h c%0d", d, i), tx_busy, 1);
      if (i != cycles - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] m, input logic t,
                            input logic hp, input logic p, input int cyc);
    @(negedge clk);
    check("ready_before_fire", data_in_ready, 1);
    data_in       = d;
    parity_mode   = m;
    two_stop      = t;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    check("line_idle_after_fire", serial_out, 1);
    check("count_after_fire", fifo_count, 1);
    @(negedge clk);
    check("count_after_pop", fifo_count, 0);
    expect_frame(d, hp, p, cyc);
    @(negedge clk);
    check("busy_low_after_frame", tx_busy, 0);
    check("line_idle_after_frame", serial_out, 1);
  endtask

  initial begin
    // {data, mode, two_stop, has_parity, parity_bit, frame_cycles}
    vecs[0] = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 100};
    vecs[1] = '{8'h07, 2'b01, 1'b0, 1'b1, 1'b1, 110};
    vecs[2] = '{8'h07, 2'b10, 1'b0, 1'b1, 1'b0, 110};
    vecs[3] = '{8'hA0, 2'b00, 1'b1, 1'b0, 1'b0, 110};
    vecs[4] = '{8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 100};
    vecs[5] = '{8'hFF, 2'b01, 1'b1, 1'b1, 1'b0, 120};
    vecs[6] = '{8'h3C, 2'b10, 1'b0, 1'b1, 1'b1, 110};
    bb[0] = 8'h11; bb[1] = 8'h22; bb[2] = 8'h33;
    bb[3] = 8'h44; bb[4] = 8'h55; bb[5] = 8'h66;

    rst           = 1'b0;
    data_in       = '0;
    data_in_valid = 1'b0;
    parity_mode   = 2'b00;
    two_stop      = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_serial", serial_out, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", data_in_ready, 0);
    rst = 1'b1;
    #1;
    check("ready_low_before_edge", data_in_ready, 0);
    @(negedge clk);
    check("ready_after_first_edge", data_in_ready, 1);

    // Table-driven single frames.
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].mode, vecs[v].two,
                 vecs[v].has_par, vecs[v].par, vecs[v].cycles);
    end

    // Six back-to-back writes from idle: one popped, four buffered, sixth refused.
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          data_in       = bb[k];
          data_in_valid = 1'b1;
          if (k == 5) begin
            check("bb_count_full", fifo_count, 4);
            check("bb_ready_low_6th", data_in_ready, 0);
          end else begin
            check($sformatf("bb_ready_high_%0d", k), data_in_ready, 1);
          end
          @(negedge clk);
        end
        data_in_valid = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
          expect_frame(bb[k], 1'b0, 1'b0, 100);
          @(negedge clk);
        end
        check("bb_busy_low_end", tx_busy, 0);
        check("bb_count_end", fifo_count, 0);
      end
    join

    // parity_mode changed mid-frame affects only the next frame.
    @(negedge clk);
    parity_mode   = 2'b00;
    two_stop      = 1'b0;
    data_in       = 8'h55;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in       = 8'h07;
    @(negedge clk);
    data_in_valid = 1'b0;
    check("tog_count", fifo_count, 1);
    fork
      begin
        repeat (50) @(negedge clk);
        parity_mode = 2'b01;
      end
      begin
        expect_frame(8'h55, 1'b0, 1'b0, 100);
        @(negedge clk);
        expect_frame(8'h07, 1'b1, 1'b1, 110);
        @(negedge clk);
        check("tog_busy_low_end", tx_busy, 0);
      end
    join

    // Reset asserted at cycle 35 of a frame while one character is queued.
    parity_mode = 2'b00;
    @(negedge clk);
    data_in       = 8'h5A;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in       = 8'h99;
    @(negedge clk);
    data_in_valid = 1'b0;
    check("rf_start_bit", serial_out, 0);
    repeat (35) @(negedge clk);
    check("rf_pre_line", serial_out, 0);
    check("rf_pre_count", fifo_count, 1);
    rst = 1'b0;
    #1;
    check("rf_line_forced_high", serial_out, 1);
    check("rf_count_cleared", fifo_count, 0);
    check("rf_busy_cleared", tx_busy, 0);
    check("rf_ready_low", data_in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rf_ready_low_after_release", data_in_ready, 0);
    @(negedge clk);
    check("rf_ready_after_edge", data_in_ready, 1);
    check("rf_line_idle", serial_out, 1);
    check("rf_busy_idle", tx_busy, 0);
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_tx_param
